// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
//   DATA_W / ADDR_W / NREG : register file geometry (8 x 16)
//   src_e                  : writeback source, also used as the round-robin pointer
package regfile_write_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

  typedef enum logic {
    SRC_A = 1'b0,  // ALU
    SRC_B = 1'b1   // load unit
  } src_e;

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   i_iss_valid/i_iss_addr : issue-stage reservation, o_iss_ready accepts it
//   i_clr_en/i_clr_addr    : write strobe/address seen by the register file
//   i_radd1/i_radd2        : decode source operands, o_stall on hazard
//   o_busy                 : busy vector
//   i_exec                 : freeze, no reservations or clears
module regfile_write_arbiter_scoreboard
  import regfile_write_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_exec,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_addr,
  output logic              o_iss_ready,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_radd1,
  input  logic [ADDR_W-1:0] i_radd2,
  output logic              o_stall,
  output logic [NREG-1:0]   o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  always_comb begin
    o_iss_ready = !i_exec && !r_busy[i_iss_addr];
    w_set = '0;
    w_clr = '0;
    if (i_iss_valid && o_iss_ready)
      w_set[i_iss_addr] = 1'b1;
    if (i_clr_en && !i_exec)
      w_clr[i_clr_addr] = 1'b1;
  end

  // Clear is applied before set so a same-edge reservation of the
  // register being written back survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_busy <= '0;
    else
      r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign o_stall = r_busy[i_radd1] | r_busy[i_radd2];
  assign o_busy  = r_busy;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU (A) and
// the load unit (B) with per-cycle round-robin, registers the write port,
// and hosts the pending-write scoreboard.
//   i_a_* / o_a_ready : ALU writeback request
//   i_b_* / o_b_ready : load-unit writeback request
//   i_iss_* / o_iss_ready, i_radd1/2, o_stall, o_busy : scoreboard
//   o_rf_*            : registered register-file write port
//   i_exec            : global freeze
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_exec,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_addr,
  output logic              o_iss_ready,
  input  logic [ADDR_W-1:0] i_radd1,
  input  logic [ADDR_W-1:0] i_radd2,
  output logic              o_stall,
  output logic [NREG-1:0]   o_busy,
  output logic              o_rf_enable,
  output logic              o_rf_wflag,
  output logic [ADDR_W-1:0] o_rf_wadd,
  output logic [DATA_W-1:0] o_rf_wdata
);

  src_e              r_rr;
  logic              r_rf_enable;
  logic              r_rf_wflag;
  logic [ADDR_W-1:0] r_rf_wadd;
  logic [DATA_W-1:0] r_rf_wdata;

  logic w_both;
  logic w_grant_a;
  logic w_grant_b;

  always_comb begin
    w_both    = i_a_valid && i_b_valid;
    w_grant_a = !i_exec && i_a_valid && (!i_b_valid || (r_rr == SRC_A));
    w_grant_b = !i_exec && i_b_valid && (!i_a_valid || (r_rr == SRC_B));
  end

  assign o_a_ready = w_grant_a;
  assign o_b_ready = w_grant_b;

  // Pointer only moves on contended grants, so an uncontended source
  // never loses its turn.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_rr <= SRC_A;
    else if (!i_exec && w_both)
      r_rr <= (r_rr == SRC_A) ? SRC_B : SRC_A;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf_enable <= 1'b0;
      r_rf_wflag  <= 1'b0;
      r_rf_wadd   <= '0;
      r_rf_wdata  <= '0;
    end else begin
      r_rf_enable <= !i_exec;
      r_rf_wflag  <= w_grant_a || w_grant_b;
      if (w_grant_a) begin
        r_rf_wadd  <= i_a_addr;
        r_rf_wdata <= i_a_data;
      end else if (w_grant_b) begin
        r_rf_wadd  <= i_b_addr;
        r_rf_wdata <= i_b_data;
      end
    end
  end

  assign o_rf_enable = r_rf_enable;
  assign o_rf_wflag  = r_rf_wflag;
  assign o_rf_wadd   = r_rf_wadd;
  assign o_rf_wdata  = r_rf_wdata;

  regfile_write_arbiter_scoreboard u_scoreboard (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_exec      (i_exec),
    .i_iss_valid (i_iss_valid),
    .i_iss_addr  (i_iss_addr),
    .o_iss_ready (o_iss_ready),
    .i_clr_en    (r_rf_wflag),
    .i_clr_addr  (r_rf_wadd),
    .i_radd1     (i_radd1),
    .i_radd2     (i_radd2),
    .o_stall     (o_stall),
    .o_busy      (o_busy)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        exec;
  logic        a_valid;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [2:0]  b_addr;
  logic [15:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [2:0]  iss_addr;
  logic        iss_ready;
  logic [2:0]  radd1;
  logic [2:0]  radd2;
  logic        stall;
  logic [7:0]  busy;
  logic        rf_enable;
  logic        rf_wflag;
  logic [2:0]  rf_wadd;
  logic [15:0] rf_wdata;

  regfile_write_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_exec      (exec),
    .i_a_valid   (a_valid),
    .i_a_addr    (a_addr),
    .i_a_data    (a_data),
    .o_a_ready   (a_ready),
    .i_b_valid   (b_valid),
    .i_b_addr    (b_addr),
    .i_b_data    (b_data),
    .o_b_ready   (b_ready),
    .i_iss_valid (iss_valid),
    .i_iss_addr  (iss_addr),
    .o_iss_ready (iss_ready),
    .i_radd1     (radd1),
    .i_radd2     (radd2),
    .o_stall     (stall),
    .o_busy      (busy),
    .o_rf_enable (rf_enable),
    .o_rf_wflag  (rf_wflag),
    .o_rf_wadd   (rf_wadd),
    .o_rf_wdata  (rf_wdata)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [18:0] exp_q[$];
  logic        m_rr;   // 0 = A next on contention, 1 = B

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_grant(input logic av, input logic bv,
                                             input logic ex, input logic rr);
    logic ga, gb;
    ga = !ex && av && (!bv || !rr);
    gb = !ex && bv && (!av || rr);
    return {ga, gb};
  endfunction

  // Reference model of the edge about to happen: queue accepted write, move pointer.
  task automatic model_step();
    logic [1:0] g;
    g = model_grant(a_valid, b_valid, exec, m_rr);
    if (g[1])      exp_q.push_back({a_addr, a_data});
    else if (g[0]) exp_q.push_back({b_addr, b_data});
    if (!exec && a_valid && b_valid) m_rr = ~m_rr;
  endtask

  // Scoreboard consumer: every register-file write must match the next queued transfer.
  always @(negedge clk) begin
    if (rst_n && rf_wflag === 1'b1) begin
      logic [18:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_write: unexpected write addr=%0d data=%h, none pending", rf_wadd, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_wadd, rf_wdata} !== e) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0d data=%h expected addr=%0d data=%h",
                   rf_wadd, rf_wdata, e[18:16], e[15:0]);
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    n_tests++;
    if ({rf_enable, rf_wflag, rf_wadd, rf_wdata, busy} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_init: en=%b wflag=%b wadd=%0d wdata=%h busy=%h expected all 0",
               rf_enable, rf_wflag, rf_wadd, rf_wdata, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_rr = 1'b0;
    exp_q.delete();

    iss_valid = 1'b1; iss_addr = 3'd2;
    tick();
    iss_valid = 1'b0;
    n_tests++;
    if (busy !== 8'h04 || rf_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: busy=%h en=%b expected busy=04 en=1", busy, rf_enable);
    end

    a_valid = 1'b1; a_addr = 3'd6; a_data = 16'hBEEF;
    #1;
    model_step();
    tick();
    a_addr = 3'd7; a_data = 16'h7777;
    #5;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rf_enable, rf_wflag, rf_wadd, rf_wdata, busy} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_async: en=%b wflag=%b wadd=%0d wdata=%h busy=%h expected all 0",
               rf_enable, rf_wflag, rf_wadd, rf_wdata, busy);
    end
    tick();
    n_tests++;
    if ({rf_enable, rf_wflag, rf_wadd, rf_wdata, busy} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_dropped: en=%b wflag=%b wadd=%0d wdata=%h busy=%h expected all 0",
               rf_enable, rf_wflag, rf_wadd, rf_wdata, busy);
    end
    rst_n = 1'b1;
    m_rr = 1'b0;
    exp_q.delete();
    #1;
    n_tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ready_a: ready=%b expected 10", {a_ready, b_ready});
    end
    a_valid = 1'b0; b_valid = 1'b1;
    #1;
    n_tests++;
    if ({a_ready, b_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_ready_b: ready=%b expected 01", {a_ready, b_ready});
    end
    b_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h1234;
    #1;
    n_tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ready: ready=%b expected 10", {a_ready, b_ready});
    end
    model_step();
    tick();
    a_valid = 1'b0;
    n_tests++;
    if (rf_wflag !== 1'b1 || rf_wadd !== 3'd3 || rf_wdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_write: wflag=%b wadd=%0d wdata=%h expected 1/3/1234",
               rf_wflag, rf_wadd, rf_wdata);
    end
    tick();
    n_tests++;
    if (rf_wflag !== 1'b0 || rf_wadd !== 3'd3 || rf_wdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_hold: wflag=%b wadd=%0d wdata=%h expected 0/3/1234",
               rf_wflag, rf_wadd, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_addr = 3'd1; a_data = 16'hA000 + 16'(i);
      b_valid = 1'b1; b_addr = 3'd4; b_data = 16'hB000 + 16'(i);
      #1;
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_tests++;
      if ({a_ready, b_ready} !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: ready=%b expected %b", i, {a_ready, b_ready}, exp_g);
      end
      model_step();
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_addr = 3'd5;
    #1;
    n_tests++;
    if (iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_iss_ready: iss_ready=%b expected 1", iss_ready);
    end
    tick();
    iss_valid = 1'b0;
    n_tests++;
    if (busy !== 8'h20) begin
      n_fail++;
      $display("FAIL sb_set: busy=%h expected 20", busy);
    end
    radd1 = 3'd5; radd2 = 3'd0;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_stall_r1: stall=%b expected 1", stall);
    end
    radd1 = 3'd0; radd2 = 3'd5;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_stall_r2: stall=%b expected 1", stall);
    end
    radd2 = 3'd0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_nostall: stall=%b expected 0", stall);
    end
    radd1 = 3'd5;
    a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h5555;
    #1;
    model_step();
    tick();
    a_valid = 1'b0;
    n_tests++;
    if (rf_wflag !== 1'b1 || busy !== 8'h20 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_wb_cycle: wflag=%b busy=%h stall=%b expected 1/20/1", rf_wflag, busy, stall);
    end
    tick();
    n_tests++;
    if (busy !== 8'h00 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear: busy=%h stall=%b expected 00/0", busy, stall);
    end
    radd1 = 3'd0;
  endtask

  task automatic test_set_clear();
    iss_valid = 1'b1; iss_addr = 3'd5;
    tick();
    #1;
    n_tests++;
    if (iss_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_iss_blocked: iss_ready=%b expected 0", iss_ready);
    end
    tick();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h0A0A;
    #1;
    model_step();
    tick();
    a_valid = 1'b0;
    tick();
    n_tests++;
    if (busy !== 8'h00) begin
      n_fail++;
      $display("FAIL sc_clear: busy=%h expected 00", busy);
    end
    // Write to a free register, then reserve it on its writeback edge.
    a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h0C0C;
    #1;
    model_step();
    tick();
    a_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 3'd5;
    #1;
    n_tests++;
    if (iss_ready !== 1'b1 || rf_wflag !== 1'b1 || rf_wadd !== 3'd5) begin
      n_fail++;
      $display("FAIL sc_setup: iss_ready=%b wflag=%b wadd=%0d expected 1/1/5", iss_ready, rf_wflag, rf_wadd);
    end
    tick();
    iss_valid = 1'b0;
    n_tests++;
    if (busy !== 8'h20) begin
      n_fail++;
      $display("FAIL sc_set_wins: busy=%h expected 20", busy);
    end
  endtask

  task automatic test_exec();
    // One contended grant to A leaves the pointer at B.
    a_valid = 1'b1; a_addr = 3'd0; a_data = 16'h1111;
    b_valid = 1'b1; b_addr = 3'd0; b_data = 16'h2222;
    #1;
    model_step();
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    exec = 1'b1;
    a_valid = 1'b1; a_addr = 3'd2; a_data = 16'h2A2A;
    b_valid = 1'b1; b_addr = 3'd6; b_data = 16'h6B6B;
    iss_valid = 1'b1; iss_addr = 3'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if ({a_ready, b_ready, iss_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL exec_ready[%0d]: a=%b b=%b iss=%b expected 000", i, a_ready, b_ready, iss_ready);
      end
      model_step();
      tick();
      n_tests++;
      if (rf_wflag !== 1'b0 || rf_enable !== 1'b0 || busy !== 8'h20) begin
        n_fail++;
        $display("FAIL exec_hold[%0d]: wflag=%b en=%b busy=%h expected 0/0/20", i, rf_wflag, rf_enable, busy);
      end
    end
    exec = 1'b0;
    iss_valid = 1'b0;
    #1;
    n_tests++;
    if ({a_ready, b_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL exec_resume: ready=%b expected 01", {a_ready, b_ready});
    end
    model_step();
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    n_tests++;
    if (rf_wflag !== 1'b1 || rf_enable !== 1'b1 || rf_wadd !== 3'd6) begin
      n_fail++;
      $display("FAIL exec_after: wflag=%b en=%b wadd=%0d expected 1/1/6", rf_wflag, rf_enable, rf_wadd);
    end
    tick();
  endtask

  task automatic test_drain();
    repeat (3) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d writes never seen, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; exec = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
    radd1 = '0; radd2 = '0;
    m_rr = 1'b0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_scoreboard();
    test_set_clear();
    test_exec();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
